// File: rtl/cave_input_ctrl_if.sv
// Player-input bus for cave_input_ctrl.
// The host side (hps_io or a bench) drives the inputs: ps2_key, joystick and autofire_en.
// The controller drives the registered per-player outputs.
//   ps2_key      [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code
//   joystick     32 bits per player; player p uses [32p+31:32p]
//   autofire_en  bit p*BUTTONS+b enables autofire for player p, button b
//   up/down/left/right/start/coin/pause/service  one bit per player
//   buttons      same indexing as autofire_en
interface cave_input_ctrl_if #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 3
);
  logic [10:0]                ps2_key;
  logic [32*PLAYERS-1:0]      joystick;
  logic [BUTTONS*PLAYERS-1:0] autofire_en;
  logic [PLAYERS-1:0]         up;
  logic [PLAYERS-1:0]         down;
  logic [PLAYERS-1:0]         left;
  logic [PLAYERS-1:0]         right;
  logic [BUTTONS*PLAYERS-1:0] buttons;
  logic [PLAYERS-1:0]         start;
  logic [PLAYERS-1:0]         coin;
  logic [PLAYERS-1:0]         pause;
  logic [PLAYERS-1:0]         service;

  modport master (
    output ps2_key, joystick, autofire_en,
    input  up, down, left, right, buttons, start, coin, pause, service
  );

  modport slave (
    input  ps2_key, joystick, autofire_en,
    output up, down, left, right, buttons, start, coin, pause, service
  );
endinterface

// File: rtl/cave_input_ctrl.sv
// Player-input front end for the Cave core.
// Decodes PS/2 make/break events into key state and ORs the keys with the joystick words.
// It adds per-button autofire, optional opposing-direction neutralisation and fixed-width coin pulses.
// Ports:
//   clk_sys  system clock
//   RESET    asynchronous, active-high reset
//   bus      cave_input_ctrl_if slave; all outputs are registered in clk_sys
//
// Autofire FSM, one per button:
//   state   | meaning
//   AF_IDLE | output follows the merged raw button
//   AF_FIRE | button held with autofire on; output is the square-wave phase
module cave_input_ctrl #(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 3,
  parameter int AUTOFIRE_DIV = 2000000,
  parameter int COIN_PULSE   = 4000000,
  parameter int SOCD_NEUTRAL = 1
) (
  input logic         clk_sys,
  input logic         RESET,
  cave_input_ctrl_if.slave bus
);

  localparam int W  = 8 + BUTTONS;
  localparam int NB = PLAYERS * BUTTONS;
  localparam int AW = $clog2(AUTOFIRE_DIV);
  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam logic [AW-1:0] AF_RELOAD = AW'(AUTOFIRE_DIV - 1);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE);
  localparam logic SOCD_ON = (SOCD_NEUTRAL != 0);

  localparam int I_RIGHT   = 0;
  localparam int I_LEFT    = 1;
  localparam int I_DOWN    = 2;
  localparam int I_UP      = 3;
  localparam int I_BTN     = 4;
  localparam int I_START   = 4 + BUTTONS;
  localparam int I_COIN    = 5 + BUTTONS;
  localparam int I_PAUSE   = 6 + BUTTONS;
  localparam int I_SERVICE = 7 + BUTTONS;

  typedef enum logic {AF_IDLE, AF_FIRE} af_state_t;

  // Map a scan code to its bit in the joystick-format word of player p.
  // The function returns -1 when the code does not belong to that player.
  function automatic int key_idx(input int p, input logic [7:0] code);
    int idx;
    idx = -1;
    if (p == 0) begin
      case (code)
        8'h75: idx = I_UP;
        8'h72: idx = I_DOWN;
        8'h6B: idx = I_LEFT;
        8'h74: idx = I_RIGHT;
        8'h14: idx = I_BTN;
        8'h11: if (BUTTONS > 1) idx = I_BTN + 1;
        8'h29: if (BUTTONS > 2) idx = I_BTN + 2;
        8'h16: idx = I_START;
        8'h2E: idx = I_COIN;
        8'h4D: idx = I_PAUSE;
        8'h46: idx = I_SERVICE;
        default: idx = -1;
      endcase
    end else if (p == 1) begin
      case (code)
        8'h2D: idx = I_UP;
        8'h2B: idx = I_DOWN;
        8'h23: idx = I_LEFT;
        8'h34: idx = I_RIGHT;
        8'h1C: idx = I_BTN;
        8'h1B: if (BUTTONS > 1) idx = I_BTN + 1;
        8'h15: if (BUTTONS > 2) idx = I_BTN + 2;
        8'h1E: idx = I_START;
        8'h36: idx = I_COIN;
        8'h45: idx = I_SERVICE;
        default: idx = -1;
      endcase
    end
    return idx;
  endfunction

  logic                      old_toggle;
  logic                      key_strobe;
  logic [PLAYERS-1:0][W-1:0] key_q;
  logic [PLAYERS-1:0][W-1:0] raw_q;
  logic [PLAYERS-1:0][W-1:0] raw_d;

  af_state_t      af_state   [NB];
  af_state_t      af_state_n [NB];
  logic [AW-1:0]  af_cnt     [NB];
  logic [AW-1:0]  af_cnt_n   [NB];
  logic [NB-1:0]  af_phase, af_phase_n;

  logic [CW-1:0]  coin_cnt   [PLAYERS];
  logic [CW-1:0]  coin_cnt_n [PLAYERS];

  logic [PLAYERS-1:0] up_q, down_q, left_q, right_q, start_q, coin_q, pause_q, service_q;
  logic [PLAYERS-1:0] up_n, down_n, left_n, right_n, start_n, coin_n, pause_n, service_n;
  logic [NB-1:0]      btn_q, btn_n;

  assign key_strobe = bus.ps2_key[10] ^ old_toggle;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      old_toggle <= 1'b0;
      key_q      <= '0;
    end else begin
      old_toggle <= bus.ps2_key[10];
      if (key_strobe) begin
        for (int p = 0; p < PLAYERS; p++) begin
          for (int i = 0; i < W; i++) begin
            if (key_idx(p, bus.ps2_key[7:0]) == i) key_q[p][i] <= bus.ps2_key[9];
          end
        end
      end
    end
  end

  // raw_d holds the previous merged word, which is used for rising-edge detection.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      raw_q <= '0;
      raw_d <= '0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) raw_q[p] <= key_q[p] | bus.joystick[32*p +: W];
      raw_d <= raw_q;
    end
  end

  always_comb begin
    af_state_n = af_state;
    af_cnt_n   = af_cnt;
    af_phase_n = af_phase;
    coin_cnt_n = coin_cnt;
    btn_n      = '0;
    up_n       = '0;
    down_n     = '0;
    left_n     = '0;
    right_n    = '0;
    start_n    = '0;
    coin_n     = '0;
    pause_n    = '0;
    service_n  = '0;

    for (int p = 0; p < PLAYERS; p++) begin
      up_n[p]      = raw_q[p][I_UP]    & ~(SOCD_ON & raw_q[p][I_DOWN]);
      down_n[p]    = raw_q[p][I_DOWN]  & ~(SOCD_ON & raw_q[p][I_UP]);
      left_n[p]    = raw_q[p][I_LEFT]  & ~(SOCD_ON & raw_q[p][I_RIGHT]);
      right_n[p]   = raw_q[p][I_RIGHT] & ~(SOCD_ON & raw_q[p][I_LEFT]);
      start_n[p]   = raw_q[p][I_START];
      pause_n[p]   = raw_q[p][I_PAUSE];
      service_n[p] = raw_q[p][I_SERVICE];

      for (int b = 0; b < BUTTONS; b++) begin
        case (af_state[p*BUTTONS+b])
          AF_IDLE: begin
            btn_n[p*BUTTONS+b] = raw_q[p][I_BTN+b];
            if (bus.autofire_en[p*BUTTONS+b] && raw_q[p][I_BTN+b] && !raw_d[p][I_BTN+b]) begin
              af_state_n[p*BUTTONS+b] = AF_FIRE;
              af_cnt_n[p*BUTTONS+b]   = AF_RELOAD;
              af_phase_n[p*BUTTONS+b] = 1'b1;
            end
          end
          AF_FIRE: begin
            if (!bus.autofire_en[p*BUTTONS+b] || !raw_q[p][I_BTN+b]) begin
              af_state_n[p*BUTTONS+b] = AF_IDLE;
              af_cnt_n[p*BUTTONS+b]   = '0;
              af_phase_n[p*BUTTONS+b] = 1'b0;
              btn_n[p*BUTTONS+b]      = raw_q[p][I_BTN+b];
            end else if (af_cnt[p*BUTTONS+b] == '0) begin
              af_cnt_n[p*BUTTONS+b]   = AF_RELOAD;
              af_phase_n[p*BUTTONS+b] = ~af_phase[p*BUTTONS+b];
              btn_n[p*BUTTONS+b]      = ~af_phase[p*BUTTONS+b];
            end else begin
              af_cnt_n[p*BUTTONS+b]   = af_cnt[p*BUTTONS+b] - AW'(1);
              btn_n[p*BUTTONS+b]      = af_phase[p*BUTTONS+b];
            end
          end
          default: begin
            af_state_n[p*BUTTONS+b] = AF_IDLE;
          end
        endcase
      end

      // Fixed-width pulse; edges while it is running are dropped.
      if (raw_q[p][I_COIN] && !raw_d[p][I_COIN] && coin_cnt[p] == '0) begin
        coin_cnt_n[p] = COIN_LOAD;
      end else if (coin_cnt[p] != '0) begin
        coin_cnt_n[p] = coin_cnt[p] - CW'(1);
      end
      coin_n[p] = (coin_cnt_n[p] != '0);
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NB; i++) begin
        af_state[i] <= AF_IDLE;
        af_cnt[i]   <= '0;
      end
      for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= '0;
      af_phase  <= '0;
      btn_q     <= '0;
      up_q      <= '0;
      down_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      start_q   <= '0;
      coin_q    <= '0;
      pause_q   <= '0;
      service_q <= '0;
    end else begin
      af_state  <= af_state_n;
      af_cnt    <= af_cnt_n;
      coin_cnt  <= coin_cnt_n;
      af_phase  <= af_phase_n;
      btn_q     <= btn_n;
      up_q      <= up_n;
      down_q    <= down_n;
      left_q    <= left_n;
      right_q   <= right_n;
      start_q   <= start_n;
      coin_q    <= coin_n;
      pause_q   <= pause_n;
      service_q <= service_n;
    end
  end

  assign bus.up      = up_q;
  assign bus.down    = down_q;
  assign bus.left    = left_q;
  assign bus.right   = right_q;
  assign bus.buttons = btn_q;
  assign bus.start   = start_q;
  assign bus.coin    = coin_q;
  assign bus.pause   = pause_q;
  assign bus.service = service_q;

  // The extended flag, the joystick bits above the map and the non-edge-detected raw_d bits are not used.
  logic unused_bits;
  assign unused_bits = ^{bus.ps2_key[8], bus.joystick, raw_d};

endmodule

// File: tb/tb_cave_input_ctrl.sv
module tb_cave_input_ctrl;

  logic clk_sys = 1'b0;
  logic RESET;
  always #5 clk_sys = ~clk_sys;

  cave_input_ctrl_if #(.PLAYERS(2), .BUTTONS(3)) bus ();
  cave_input_ctrl_if #(.PLAYERS(4), .BUTTONS(6)) bus4 ();

  cave_input_ctrl #(.PLAYERS(2), .BUTTONS(3), .AUTOFIRE_DIV(4), .COIN_PULSE(10), .SOCD_NEUTRAL(1))
    u_dut (.clk_sys(clk_sys), .RESET(RESET), .bus(bus));

  cave_input_ctrl #(.PLAYERS(4), .BUTTONS(6), .AUTOFIRE_DIV(4), .COIN_PULSE(10), .SOCD_NEUTRAL(0))
    u_dut4 (.clk_sys(clk_sys), .RESET(RESET), .bus(bus4));

  int   n_cmp = 0;
  int   n_bad = 0;
  logic tog   = 1'b0;

  typedef struct {
    logic [15:0] j0;
    logic [15:0] j1;
    logic [19:0] exp;
  } vec_t;

  vec_t vt [10];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ps2(input logic [7:0] code, input logic pressed);
    @(negedge clk_sys);
    tog = ~tog;
    bus.ps2_key = {tog, pressed, 1'b0, code};
  endtask

  task automatic set_joy(input logic [15:0] j0, input logic [15:0] j1);
    @(negedge clk_sys);
    bus.joystick = {16'h0, j1, 16'h0, j0};
  endtask

  task automatic count_coin(input int n, inout int c);
    repeat (n) begin
      step();
      if (bus.coin[0]) c++;
    end
  endtask

  function automatic logic [19:0] mk(input logic [5:0] b, input logic [1:0] u, input logic [1:0] d,
                                     input logic [1:0] l, input logic [1:0] r, input logic [1:0] s,
                                     input logic [1:0] pa, input logic [1:0] sv);
    return {b, u, d, l, r, s, pa, sv};
  endfunction

  function automatic logic [19:0] snap_a();
    return {bus.buttons, bus.up, bus.down, bus.left, bus.right, bus.start, bus.pause, bus.service};
  endfunction

  function automatic logic [31:0] snap_b();
    return {bus4.up, bus4.down, bus4.left, bus4.right, bus4.start, bus4.coin, bus4.pause, bus4.service};
  endfunction

  initial begin
    int c;
    // P0 bits: r0 l1 d2 u3 b4..6 start7 coin8 pause9 service10
    vt[0] = '{16'h0008, 16'h0000, mk(6'b000000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vt[1] = '{16'h000C, 16'h0000, mk(6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vt[2] = '{16'h0003, 16'h0000, mk(6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vt[3] = '{16'h000A, 16'h0000, mk(6'b000000, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00)};
    vt[4] = '{16'h0070, 16'h0000, mk(6'b000111, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vt[5] = '{16'h0000, 16'h0010, mk(6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vt[6] = '{16'h0680, 16'h0000, mk(6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01)};
    vt[7] = '{16'h0000, 16'h0401, mk(6'b000000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10)};
    vt[8] = '{16'h000C, 16'h0004, mk(6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vt[9] = '{16'h0059, 16'h0083, mk(6'b000101, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00)};

    RESET = 1'b1;
    bus.ps2_key = '0;  bus.joystick = '0;  bus.autofire_en = '0;
    bus4.ps2_key = '0; bus4.joystick = '0; bus4.autofire_en = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_a", 32'(snap_a()), 32'h0);
    check("reset_a_coin", 32'(bus.coin), 32'h0);
    check("reset_b", snap_b(), 32'h0);
    check("reset_b_btn", 32'(bus4.buttons), 32'h0);
    @(negedge clk_sys);
    RESET = 1'b0;
    step(); step();
    check("post_reset_a", 32'(snap_a()), 32'h0);

    // Steady-state table
    for (int i = 0; i < 10; i++) begin
      set_joy(vt[i].j0, vt[i].j1);
      repeat (3) step();
      check($sformatf("vec%0d", i), 32'(snap_a()), 32'(vt[i].exp));
    end
    set_joy(16'h0, 16'h0);
    repeat (3) step();

    // Keyboard latency: 3 cycles from the toggle
    ps2(8'h75, 1'b1);
    step(); step();
    check("kbd_up_lat2", 32'(bus.up), 32'h0);
    step();
    check("kbd_up_lat3", 32'(bus.up), 32'h1);
    ps2(8'h75, 1'b0);
    step(); step();
    check("kbd_up_rel_lat2", 32'(bus.up), 32'h1);
    step();
    check("kbd_up_rel_lat3", 32'(bus.up), 32'h0);

    // Key release while the joystick still holds the direction
    ps2(8'h75, 1'b1);
    set_joy(16'h0008, 16'h0);
    repeat (3) step();
    ps2(8'h75, 1'b0);
    repeat (4) step();
    check("kbd_rel_joy_held", 32'(bus.up), 32'h1);
    set_joy(16'h0, 16'h0);
    repeat (3) step();
    check("joy_rel_up", 32'(bus.up), 32'h0);

    ps2(8'h1B, 1'b1);
    repeat (4) step();
    check("kbd_p1_btn1", 32'(snap_a()), 32'(mk(6'b010000, 0, 0, 0, 0, 0, 0, 0)));
    ps2(8'h1B, 1'b0);
    ps2(8'h4D, 1'b1);
    repeat (4) step();
    check("kbd_p0_pause", 32'(snap_a()), 32'(mk(6'b000000, 0, 0, 0, 0, 0, 2'b01, 0)));
    ps2(8'h4D, 1'b0);
    ps2(8'h2B, 1'b1);
    ps2(8'h45, 1'b1);
    repeat (4) step();
    check("kbd_p1_down_srv", 32'(snap_a()), 32'(mk(6'b000000, 0, 2'b10, 0, 0, 0, 0, 2'b10)));
    ps2(8'h2B, 1'b0);
    ps2(8'h45, 1'b0);
    ps2(8'h99, 1'b1);
    repeat (4) step();
    check("kbd_unmatched", 32'(snap_a()), 32'h0);
    @(negedge clk_sys);
    bus.ps2_key = {tog, 1'b1, 1'b0, 8'h74};
    repeat (4) step();
    check("kbd_no_toggle", 32'(bus.right), 32'h0);

    // SOCD release: 2-cycle joystick latency
    set_joy(16'h000C, 16'h0);
    repeat (3) step();
    check("socd_ud", 32'({bus.up, bus.down}), 32'h0);
    set_joy(16'h0008, 16'h0);
    step();
    check("socd_rel_lat1", 32'(bus.up), 32'h0);
    step();
    check("socd_rel_lat2", 32'(bus.up), 32'h1);
    set_joy(16'h0, 16'h0);
    repeat (3) step();

    // Autofire pattern 1111 0000 1111
    @(negedge clk_sys);
    bus.autofire_en = 6'b000001;
    set_joy(16'h0010, 16'h0);
    step(); step();
    for (int k = 0; k < 12; k++) begin
      check($sformatf("af_pat%0d", k), 32'(bus.buttons[0]), 32'(((k / 4) % 2) == 0));
      if (k < 11) step();
    end
    set_joy(16'h0, 16'h0);
    repeat (4) step();
    check("af_idle", 32'(bus.buttons[0]), 32'h0);

    // Release during a high phase: 0 regardless of phase
    set_joy(16'h0010, 16'h0);
    step(); step();
    repeat (9) step();
    set_joy(16'h0, 16'h0);
    step(); step();
    check("af_release", 32'(bus.buttons[0]), 32'h0);
    repeat (3) step();

    // Enable dropped during the low phase: output follows raw
    set_joy(16'h0010, 16'h0);
    step(); step();
    repeat (4) step();
    check("af_low_phase", 32'(bus.buttons[0]), 32'h0);
    @(negedge clk_sys);
    bus.autofire_en = 6'b000000;
    step();
    check("af_en_drop", 32'(bus.buttons[0]), 32'h1);
    repeat (6) step();
    check("af_en_drop_hold", 32'(bus.buttons[0]), 32'h1);
    set_joy(16'h0, 16'h0);
    repeat (3) step();

    // Coin held for 50 cycles: exactly 10 cycles high
    set_joy(16'h0100, 16'h0);
    step();
    check("coin_lat1", 32'(bus.coin[0]), 32'h0);
    step();
    check("coin_lat2", 32'(bus.coin[0]), 32'h1);
    c = 1;
    count_coin(48, c);
    check("coin_hold_width", 32'(c), 32'd10);
    set_joy(16'h0, 16'h0);
    repeat (3) step();

    // A second edge inside the pulse is ignored
    c = 0;
    set_joy(16'h0100, 16'h0);
    count_coin(5, c);
    set_joy(16'h0, 16'h0);
    count_coin(2, c);
    set_joy(16'h0100, 16'h0);
    count_coin(30, c);
    check("coin_reedge_width", 32'(c), 32'd10);
    set_joy(16'h0, 16'h0);
    repeat (3) step();

    // A short tap still gives a full pulse
    c = 0;
    set_joy(16'h0100, 16'h0);
    set_joy(16'h0, 16'h0);
    count_coin(30, c);
    check("coin_tap_width", 32'(c), 32'd10);

    // Reset mid-pulse with coin held
    set_joy(16'h0108, 16'h0);
    repeat (4) step();
    check("coin_pre_reset", 32'({bus.coin[0], bus.up[0]}), 32'h3);
    @(negedge clk_sys);
    RESET = 1'b1;
    #1;
    check("reset_mid_a", 32'(snap_a()), 32'h0);
    check("reset_mid_coin", 32'(bus.coin), 32'h0);
    @(negedge clk_sys);
    RESET = 1'b0;
    c = 0;
    count_coin(30, c);
    check("coin_after_reset", 32'(c), 32'd10);
    check("up_after_reset", 32'(bus.up), 32'h1);
    set_joy(16'h0, 16'h0);
    repeat (3) step();

    // Four players, six buttons, raw OR
    @(negedge clk_sys);
    bus4.joystick[32*3+4+5] = 1'b1;
    step(); step();
    check("p4_btn23", 32'(bus4.buttons), 32'h0080_0000);
    @(negedge clk_sys);
    bus4.joystick = '0;
    bus4.joystick[32*3+13] = 1'b1;
    step(); step();
    check("p4_service3", snap_b(), 32'h0000_0008);
    @(negedge clk_sys);
    bus4.joystick = '0;
    bus4.joystick[32*2+3] = 1'b1;
    bus4.joystick[32*2+2] = 1'b1;
    bus4.joystick[32*1+10] = 1'b1;
    step(); step();
    check("p4_no_socd", snap_b(), {4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0010, 4'b0, 4'b0, 4'b0});
    @(negedge clk_sys);
    bus4.joystick = '0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
